// File: rtl/rom_chip_pkg.sv
// Shared constants and types for the 556PT5/556PT4 fusible-link PROM programmer.
// Defines the chip IDs, the V1..V4 operation codes, the error codes and the programmer states.
package rom_chip_pkg;

  localparam int IP3604 = 1;
  localparam int IP3601 = 2;

  localparam int IP3604_DATA_WIDTH    = 8;
  localparam int IP3604_ADDRESS_WIDTH = 9;
  localparam int IP3601_DATA_WIDTH    = 4;
  localparam int IP3601_ADDRESS_WIDTH = 8;

  localparam logic [3:0] OP_READ = 4'b1100;
  localparam logic [3:0] OP_PROG = 4'b1010;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CONFLICT = 2'd1,
    ERR_RETRY    = 2'd2,
    ERR_VERIFY   = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    RECOVER,
    VERIFY,
    FINAL_VERIFY,
    DONE,
    FAIL
  } state_e;

endpackage

// File: rtl/rom_prog_timer.sv
// Loadable down-counter used for the settle and programming-pulse waits.
// zero_o marks the last cycle of a wait that was loaded with (length - 1).
module rom_prog_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_value_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/rom_programmer.sv
// Burns one word per request into a fusible-link PROM: blank-check, pulse each missing bit, verify, retry.
// Optional whole-word re-read after the last bit is enabled with macro ROM_PROG_FINAL_VERIFY_EN.
module rom_programmer
  import rom_chip_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int PULSE_CYCLES  = 1000,
  parameter int SETTLE_CYCLES = 50,
  parameter int MAX_RETRIES   = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  output logic                          ready,
  input  logic [ADDRESS_WIDTH-1:0]      prog_address,
  input  logic [DATA_WIDTH-1:0]         prog_data,
  input  logic [DATA_WIDTH-1:0]         data_line_in,
  output logic [3:0]                    operation,
  output logic [ADDRESS_WIDTH-1:0]      address_line,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [DATA_WIDTH-1:0]         data_oe,
  output logic                          done,
  output logic                          error,
  output logic [1:0]                    err_code,
  output logic [$clog2(DATA_WIDTH)-1:0] fail_bit
);

  localparam int BIT_W     = $clog2(DATA_WIDTH);
  localparam int RETRY_W   = $clog2(MAX_RETRIES + 1);
  localparam int TIMER_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] PULSE_LOAD  = TIMER_W'(PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  function automatic logic [BIT_W-1:0] lowestBit(input logic [DATA_WIDTH-1:0] v);
    lowestBit = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (v[i]) lowestBit = BIT_W'(i);
    end
  endfunction

  function automatic logic [DATA_WIDTH-1:0] oneHot(input logic [BIT_W-1:0] b);
    oneHot    = '0;
    oneHot[b] = 1'b1;
  endfunction

  state_e                   state_q;
  err_code_e                errCode_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0]    target_q;
  logic [DATA_WIDTH-1:0]    pending_q;
  logic [BIT_W-1:0]         bitSel_q;
  logic [RETRY_W-1:0]       retryCount_q;
  logic [3:0]               operation_q;
  logic [DATA_WIDTH-1:0]    dataOe_q;
  logic                     ready_q;
  logic                     done_q;
  logic                     error_q;
  logic [BIT_W-1:0]         failBit_q;

  logic [DATA_WIDTH-1:0]    readConflict;
  logic [DATA_WIDTH-1:0]    readPending;
  logic [DATA_WIDTH-1:0]    pending_d;
  logic [RETRY_W-1:0]       retryCount_d;
  logic                     verifyPass;

  logic                     timerLoad;
  logic [TIMER_W-1:0]       timerValue;
  logic                     timerEn;
  logic                     timerZero;

  assign readConflict = data_line_in & ~target_q;
  assign readPending  = target_q & ~data_line_in;
  assign pending_d    = pending_q & ~oneHot(bitSel_q);
  assign retryCount_d = retryCount_q + RETRY_W'(1);
  assign verifyPass   = data_line_in[bitSel_q];

  // Each wait is loaded on the edge that enters it, so the timer hits zero on its last cycle.
  always_comb begin
    timerLoad  = 1'b0;
    timerValue = SETTLE_LOAD;
    timerEn    = 1'b0;
    case (state_q)
      IDLE:         timerLoad = start;
      SETUP: begin
        timerLoad  = timerZero;
        timerValue = PULSE_LOAD;
        timerEn    = 1'b1;
      end
      PULSE: begin
        timerLoad = timerZero;
        timerEn   = 1'b1;
      end
      RECOVER:      timerEn = 1'b1;
      VERIFY: begin
        timerLoad  = 1'b1;
        timerValue = (verifyPass && (pending_d == '0)) ? SETTLE_LOAD : PULSE_LOAD;
      end
      FINAL_VERIFY: timerEn = 1'b1;
      default: begin
        timerLoad  = 1'b0;
        timerValue = SETTLE_LOAD;
        timerEn    = 1'b0;
      end
    endcase
  end

  rom_prog_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (timerLoad),
    .load_value_i(timerValue),
    .en_i        (timerEn),
    .zero_o      (timerZero)
  );

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q      <= IDLE;
      errCode_q    <= ERR_NONE;
      address_q    <= '0;
      target_q     <= '0;
      pending_q    <= '0;
      bitSel_q     <= '0;
      retryCount_q <= '0;
      operation_q  <= OP_READ;
      dataOe_q     <= '0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      failBit_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            address_q    <= prog_address;
            target_q     <= prog_data;
            error_q      <= 1'b0;
            errCode_q    <= ERR_NONE;
            retryCount_q <= '0;
            ready_q      <= 1'b0;
            operation_q  <= OP_READ;
            state_q      <= SETUP;
          end
        end
        SETUP: begin
          if (timerZero) begin
            if (readConflict != '0) begin
              error_q   <= 1'b1;
              errCode_q <= ERR_CONFLICT;
              failBit_q <= lowestBit(readConflict);
              state_q   <= FAIL;
            end else if (readPending == '0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              pending_q    <= readPending;
              bitSel_q     <= lowestBit(readPending);
              retryCount_q <= '0;
              operation_q  <= OP_PROG;
              dataOe_q     <= oneHot(lowestBit(readPending));
              state_q      <= PULSE;
            end
          end
        end
        PULSE: begin
          // Drivers drop on the same edge the op code returns to read.
          if (timerZero) begin
            operation_q <= OP_READ;
            dataOe_q    <= '0;
            state_q     <= RECOVER;
          end
        end
        RECOVER: begin
          if (timerZero) state_q <= VERIFY;
        end
        VERIFY: begin
          if (verifyPass) begin
            pending_q    <= pending_d;
            retryCount_q <= '0;
            if (pending_d == '0) begin
`ifdef ROM_PROG_FINAL_VERIFY_EN
              state_q <= FINAL_VERIFY;
`else
              done_q  <= 1'b1;
              state_q <= DONE;
`endif
            end else begin
              bitSel_q    <= lowestBit(pending_d);
              operation_q <= OP_PROG;
              dataOe_q    <= oneHot(lowestBit(pending_d));
              state_q     <= PULSE;
            end
          end else begin
            retryCount_q <= retryCount_d;
            if (retryCount_d == RETRY_LIMIT) begin
              error_q   <= 1'b1;
              errCode_q <= ERR_RETRY;
              failBit_q <= bitSel_q;
              state_q   <= FAIL;
            end else begin
              operation_q <= OP_PROG;
              dataOe_q    <= oneHot(bitSel_q);
              state_q     <= PULSE;
            end
          end
        end
`ifdef ROM_PROG_FINAL_VERIFY_EN
        FINAL_VERIFY: begin
          if (timerZero) begin
            if (data_line_in == target_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              error_q   <= 1'b1;
              errCode_q <= ERR_VERIFY;
              failBit_q <= lowestBit(data_line_in ^ target_q);
              state_q   <= FAIL;
            end
          end
        end
`endif
        DONE, FAIL: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          operation_q <= OP_READ;
          dataOe_q    <= '0;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign ready        = ready_q;
  assign operation    = operation_q;
  assign address_line = address_q;
  assign data_out     = dataOe_q;
  assign data_oe      = dataOe_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = errCode_q;
  assign fail_bit     = failBit_q;

endmodule

// File: tb/tb_rom_programmer.sv
// Randomised and directed bench for rom_programmer against a behavioural fuse model.
// Expectations follow ROM_PROG_FINAL_VERIFY_EN when the macro is defined for the build.
module tb_rom_programmer;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam int PC = 4;
  localparam int SC = 2;
  localparam int MR = 3;
  localparam logic [3:0] READ_OP = 4'b1100;
  localparam logic [3:0] PROG_OP = 4'b1010;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          ready;
  logic [AW-1:0] prog_address = '0;
  logic [DW-1:0] prog_data = '0;
  logic [DW-1:0] data_line_in;
  logic [3:0]    operation;
  logic [AW-1:0] address_line;
  logic [DW-1:0] data_out;
  logic [DW-1:0] data_oe;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [2:0]    fail_bit;

  int vectors = 0;
  int miscompares = 0;

  // Fuse model: a bit blows once it has received need[bit] complete programming windows.
  logic [DW-1:0] fuse [0:(1<<AW)-1];
  int            need [DW];
  int            pulseCnt [DW];
  logic [DW-1:0] winQ [$];
  int            lenQ [$];
  logic          inWin = 1'b0;
  logic [DW-1:0] winOe = '0;
  int            winLen = 0;
  logic          checkEn = 1'b0;
  logic          decayArmed = 1'b0;

  always #5 clk = ~clk;

  assign data_line_in = fuse[address_line];

  rom_programmer #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .PULSE_CYCLES (PC),
    .SETTLE_CYCLES(SC),
    .MAX_RETRIES  (MR)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .ready       (ready),
    .prog_address(prog_address),
    .prog_data   (prog_data),
    .data_line_in(data_line_in),
    .operation   (operation),
    .address_line(address_line),
    .data_out    (data_out),
    .data_oe     (data_oe),
    .done        (done),
    .error       (error),
    .err_code    (err_code),
    .fail_bit    (fail_bit)
  );

  function automatic int lowestOf(input logic [DW-1:0] v);
    lowestOf = 0;
    for (int i = DW - 1; i >= 0; i--) if (v[i]) lowestOf = i;
  endfunction

  always @(negedge clk) begin
    if (checkEn) begin
      vectors++;
      if (!$onehot0(data_oe) || (data_out !== data_oe) ||
          ((operation === PROG_OP) !== (data_oe != '0)) ||
          ((operation !== PROG_OP) && (operation !== READ_OP))) begin
        miscompares++;
        $display("[TB] FAIL pin_invariant: operation=%b data_oe=%h data_out=%h", operation, data_oe, data_out);
      end
    end
    if (operation === PROG_OP) begin
      if (!inWin) begin
        inWin  = 1'b1;
        winLen = 0;
        winOe  = data_oe;
        if (decayArmed && (data_oe != 8'h01) && fuse[address_line][0]) fuse[address_line][0] = 1'b0;
      end
      winLen++;
    end else if (inWin) begin
      int b;
      inWin = 1'b0;
      winQ.push_back(winOe);
      lenQ.push_back(winLen);
      b = lowestOf(winOe);
      pulseCnt[b]++;
      if (pulseCnt[b] >= need[b]) fuse[address_line][b] = 1'b1;
    end
  end

  task automatic setNeed(input int n);
    for (int i = 0; i < DW; i++) need[i] = n;
  endtask

  task automatic runAndCheck(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] init,
                             input logic [DW-1:0] target, input bit holdStart);
    logic [DW-1:0] expQ [$];
    logic [DW-1:0] expWord;
    logic [DW-1:0] conflict;
    int expCode, expBit, lat, doneCnt, doneCyc, errCyc, readyCyc, waitCnt;
    bit bit0Blown, addrBad;

    // Reference outcome derived from the programming rules.
    expCode = 0; expBit = 0; expWord = init; lat = SC; bit0Blown = 0;
    conflict = init & ~target;
    if (conflict != '0) begin
      expCode = 1; expBit = lowestOf(conflict);
    end else begin
      for (int b = 0; b < DW; b++) begin
        if (target[b] && !init[b]) begin
          int n;
          n = (need[b] > MR) ? MR : need[b];
          if (decayArmed && b > 0 && bit0Blown) expWord[0] = 1'b0;
          for (int k = 0; k < n; k++) begin
            expQ.push_back(DW'(1) << b);
            lat += PC + SC + 1;
          end
          if (need[b] > MR) begin
            expCode = 2; expBit = b;
            break;
          end
          expWord[b] = 1'b1;
          if (b == 0) bit0Blown = 1;
        end
      end
`ifdef ROM_PROG_FINAL_VERIFY_EN
      if (expCode == 0 && expQ.size() > 0) begin
        lat += SC;
        if (expWord != target) begin
          expCode = 3; expBit = lowestOf(expWord ^ target);
        end
      end
`endif
    end
    lat += 1;

    fuse[addr] = init;
    for (int i = 0; i < DW; i++) pulseCnt[i] = 0;
    winQ.delete();
    lenQ.delete();

    waitCnt = 0;
    while (ready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk); #1;
      waitCnt++;
    end
    @(negedge clk); #1;
    prog_address = addr;
    prog_data    = target;
    start        = 1'b1;
    doneCnt = 0; doneCyc = -1; errCyc = -1; readyCyc = -1; addrBad = 0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk); #1;
      if (!holdStart || cyc >= lat - 1) start = 1'b0;
      else begin
        prog_address = AW'($urandom);
        prog_data    = DW'($urandom);
      end
      if (done === 1'b1) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = cyc;
      end
      if (error === 1'b1 && errCyc < 0) errCyc = cyc;
      if (address_line !== addr) addrBad = 1;
      if (ready === 1'b1 && cyc > 1) begin
        readyCyc = cyc;
        break;
      end
    end
    start = 1'b0;

    vectors++;
    if (readyCyc != lat + 1) begin
      miscompares++;
      $display("[TB] FAIL %s ready_return: got cycle %0d expected %0d", name, readyCyc, lat + 1);
    end
    vectors++;
    if (expCode == 0) begin
      if (doneCyc != lat || doneCnt != 1 || error !== 1'b0 || err_code !== 2'd0) begin
        miscompares++;
        $display("[TB] FAIL %s done_pulse: got cycle %0d count %0d error %b code %0d expected cycle %0d count 1 error 0 code 0",
                 name, doneCyc, doneCnt, error, err_code, lat);
      end
    end else begin
      if (errCyc != lat || doneCnt != 0 || error !== 1'b1 || err_code !== 2'(expCode) || fail_bit !== 3'(expBit)) begin
        miscompares++;
        $display("[TB] FAIL %s failure_report: got cycle %0d done %0d error %b code %0d bit %0d expected cycle %0d done 0 error 1 code %0d bit %0d",
                 name, errCyc, doneCnt, error, err_code, fail_bit, lat, expCode, expBit);
      end
    end
    vectors++;
    if (winQ.size() != expQ.size()) begin
      miscompares++;
      $display("[TB] FAIL %s pulse_count: got %0d windows expected %0d", name, winQ.size(), expQ.size());
    end else begin
      for (int i = 0; i < expQ.size(); i++) begin
        if (winQ[i] !== expQ[i] || lenQ[i] != PC) begin
          miscompares++;
          $display("[TB] FAIL %s pulse_window[%0d]: got oe %h len %0d expected oe %h len %0d",
                   name, i, winQ[i], lenQ[i], expQ[i], PC);
          break;
        end
      end
    end
    vectors++;
    if (fuse[addr] !== expWord) begin
      miscompares++;
      $display("[TB] FAIL %s fuse_word: got %h expected %h", name, fuse[addr], expWord);
    end
    vectors++;
    if (addrBad) begin
      miscompares++;
      $display("[TB] FAIL %s address_hold: address_line %h expected %h", name, address_line, addr);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (ready !== 1'b1 || operation !== READ_OP || address_line !== '0 || data_out !== '0 ||
        data_oe !== '0 || done !== 1'b0 || error !== 1'b0 || err_code !== 2'd0 || fail_bit !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: ready %b op %b addr %h dout %h oe %h done %b err %b code %0d bit %0d",
               ready, operation, address_line, data_out, data_oe, done, error, err_code, fail_bit);
    end
  endtask

  task automatic test_blank_two_bits();
    setNeed(1);
    runAndCheck("blank_0x81", 9'h1A5, 8'h00, 8'h81, 1'b0);
  endtask

  task automatic test_already_programmed();
    setNeed(1);
    runAndCheck("already_0x81", 9'h1A5, 8'h81, 8'h81, 1'b0);
  endtask

  task automatic test_conflict();
    setNeed(1);
    runAndCheck("conflict", 9'h033, 8'h04, 8'h01, 1'b0);
  endtask

  task automatic test_retry_exhausted();
    setNeed(1);
    need[3] = 5;
    runAndCheck("retry_exhausted", 9'h0F0, 8'h00, 8'h08, 1'b0);
  endtask

  task automatic test_back_to_back_busy_start();
    setNeed(1);
    runAndCheck("busy_start", 9'h07E, 8'h00, 8'h24, 1'b1);
    need[1] = 2;
    runAndCheck("back_to_back", 9'h07F, 8'h10, 8'h12, 1'b1);
  endtask

  task automatic test_reset_midpulse();
    setNeed(1);
    fuse[9'h055] = 8'h00;
    @(negedge clk); #1;
    prog_address = 9'h055;
    prog_data    = 8'h81;
    start        = 1'b1;
    for (int cyc = 1; cyc <= SC + 2; cyc++) begin
      @(negedge clk); #1;
      start = 1'b0;
    end
    vectors++;
    if (operation !== PROG_OP || data_oe !== 8'h01) begin
      miscompares++;
      $display("[TB] FAIL midpulse_precondition: op %b oe %h expected op %b oe 01", operation, data_oe, PROG_OP);
    end
    reset_n = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (data_oe !== '0 || operation !== READ_OP || ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midpulse_abort: oe %h op %b ready %b expected oe 00 op %b ready 1",
               data_oe, operation, ready, READ_OP);
    end
    reset_n = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_final_verify();
    setNeed(1);
    decayArmed = 1'b1;
    runAndCheck("final_verify_decay", 9'h100, 8'h00, 8'h03, 1'b0);
    decayArmed = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 16; t++) begin
      logic [DW-1:0] init, target;
      for (int i = 0; i < DW; i++) need[i] = ($urandom_range(0, 5) == 0) ? 4 : int'($urandom_range(1, 3));
      init   = DW'($urandom) & DW'($urandom);
      target = ($urandom_range(0, 4) == 0) ? DW'($urandom) : (init | DW'($urandom));
      runAndCheck("random", AW'($urandom), init, target, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int a = 0; a < (1 << AW); a++) fuse[a] = '0;
    setNeed(1);
    for (int i = 0; i < DW; i++) pulseCnt[i] = 0;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    test_reset();
    reset_n = 1'b0;
    checkEn = 1'b1;
    test_blank_two_bits();
    test_already_programmed();
    test_conflict();
    test_retry_exhausted();
    test_back_to_back_busy_start();
    test_reset_midpulse();
    test_final_verify();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rom_programmer.md
Name: rom_programmer

Overview:
- Write-side counterpart of the 556PT5 (3604) / 556PT4 (3601) ROM reading path: burns one word per request into a fusible-link PROM.
- Host presents address plus target data; the block blank-checks, pulses each missing bit, verifies after every pulse, and retries up to a limit.
- Drives the chip's V1..V4 operation bus, the address lines and per-bit data drivers.
- Sits between the host/control logic and the chip socket, alongside the reader on the same pins.

Parameters:
- DATA_WIDTH, 8, word width (8 = 3604, 4 = 3601).
- ADDRESS_WIDTH, 9, address width (9 = 3604, 8 = 3601).
- PULSE_CYCLES, 1000, clk cycles the programming pulse is held per attempt (>=1).
- SETTLE_CYCLES, 50, clk cycles of read settling before any data sample (>=1).
- MAX_RETRIES, 8, pulse attempts per bit before failure (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, ACTIVE-HIGH (asserted = 1); codebase port name retained.
- start  in  1  request strobe; accepted only when ready=1.
- ready  out  1  idle, request can be accepted.
- prog_address  in  ADDRESS_WIDTH  target address, latched on accept.
- prog_data  in  DATA_WIDTH  target word, latched on accept.
- data_line_in  in  DATA_WIDTH  chip data outputs (readback).
- operation  out  4  V1..V4 control; bit0=V1 … bit3=V4.
- address_line  out  ADDRESS_WIDTH  chip address.
- data_out  out  DATA_WIDTH  programming drive level.
- data_oe  out  DATA_WIDTH  per-bit driver enable, at most one bit set.
- done  out  1  one-cycle pulse, word programmed OK.
- error  out  1  level, set on failure, cleared on next accepted start or reset.
- err_code  out  2  0 none, 1 conflict (blown fuse where target=0), 2 retry exhausted, 3 final-verify mismatch.
- fail_bit  out  $clog2(DATA_WIDTH)  bit index of last failure.

Behaviour:
- Reset values: ready=1, operation=OP_READ (4'b1100), address_line=0, data_out=0, data_oe=0, done=0, error=0, err_code=0, fail_bit=0, retry counter=0, state IDLE.
- Reset mid-operation aborts within one cycle: data_oe=0, operation=OP_READ. No pulse is ever truncated into an undefined op code.
- Blank fuse reads 0; programming sets a bit to 1.
- IDLE: ready=1. On start at a posedge: latch address/data, clear error/err_code, ready=0 from the next cycle, go to SETUP. start while ready=0 is ignored.
- SETUP: address_line=latched address, operation=OP_READ, held SETTLE_CYCLES cycles. Sample data_line_in on the last cycle.
  - If (read & ~target)!=0: go FAIL with code 1; fail_bit = lowest offending bit.
  - Otherwise pending = target & ~read. If pending==0, go DONE (already programmed, no pulse). Else select the lowest set pending bit and go PULSE.
- PULSE: operation=OP_PROG (4'b1010), data_oe=one-hot(bit), data_out=one-hot(bit), held exactly PULSE_CYCLES cycles.
- RECOVER: data_oe=0, operation=OP_READ, SETTLE_CYCLES cycles, then VERIFY. data_oe falls in the same cycle operation leaves OP_PROG.
- VERIFY (1 cycle):
  - If data_line_in[bit]==1: clear the pending bit and reset retries. Go to the next lowest pending bit (PULSE), or DONE if none.
  - Else increment retries. If retries==MAX_RETRIES, go FAIL with code 2, fail_bit=bit. Else PULSE again.
- DONE: done=1 for one cycle, then IDLE.
- FAIL: error=1 and err_code set, then IDLE. error holds until the next accepted start.
- Address is stable from SETUP through DONE/FAIL. address_line keeps the last address in IDLE.
- Counters are sized $clog2(max+1). No wrap is reachable.

Optional Feature:
- Macro ROM_PROG_FINAL_VERIFY_EN.
- Defined: after the last bit passes, enter FINAL_VERIFY. Hold OP_READ for SETTLE_CYCLES, compare the whole word. On equal, go DONE. On mismatch, go FAIL with code 3 and fail_bit = lowest mismatching bit.
- Undefined: go straight to DONE, and code 3 is never produced.

Decomposition:
- Package rom_chip_pkg holds:
  - chip IDs IP3604=1, IP3601=2, with data/address widths;
  - op constants OP_READ=4'b1100, OP_PROG=4'b1010;
  - err_code enum;
  - state enum IDLE/SETUP/PULSE/RECOVER/VERIFY/FINAL_VERIFY/DONE/FAIL.
- One sub-module, rom_prog_timer: loadable down-counter with load value, enable, and a zero flag, shared by the SETUP, PULSE and RECOVER waits.

Test Plan:
Bench parameters: PULSE_CYCLES=4, SETTLE_CYCLES=2, MAX_RETRIES=3; behavioural fuse model sets a bit after N pulses.
- Blank chip, addr 0x1A5, data 0x81 -> two PULSE windows of 4 cycles, data_oe 0x01 then 0x80; done pulse; model word 0x81; error=0.
- Word already 0x81, program 0x81 -> no OP_PROG cycle, done after SETUP.
- Word 0x04, program 0x01 -> FAIL, err_code=1, fail_bit=2, no pulse issued.
- Bit 3 needs 5 pulses, program 0x08 -> 3 pulses, err_code=2, fail_bit=3, ready returns 1.
- Reset asserted in the 2nd PULSE cycle -> next cycle data_oe=0, operation=4'b1100, ready=1. start held during busy has no effect.
- With ROM_PROG_FINAL_VERIFY_EN: model clears bit 0 after its verify, program 0x03 -> err_code=3, fail_bit=0.
